// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and data access.
// Define ARB_FAIR_EN to stop a continuous stream of D requests from starving fetch.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          err
);

    localparam int unsigned WW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state;
    logic [WW-1:0] wd_cnt;
    logic          ack_cycle;
    logic          done;
    logic          timeout;
    logic          grant_d;
    logic          grant_i;
`ifdef ARB_FAIR_EN
    logic [1:0]    fair_cnt;
`endif

    // A requester still sees its ack this cycle and may not have dropped req yet.
    assign ack_cycle = i_ack | d_ack;
    assign done      = (state != IDLE) && m_ready;
    assign timeout   = (TIMEOUT != 0) && (state != IDLE) && !m_ready &&
                       ((wd_cnt + 1'b1) == WD_LIMIT);

    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE && !ack_cycle) begin
`ifdef ARB_FAIR_EN
            if (d_req && !(i_req && fair_cnt == 2'd2)) grant_d = 1'b1;
`else
            if (d_req) grant_d = 1'b1;
`endif
            else if (i_req) grant_i = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wd_cnt  <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            err     <= 1'b0;
`ifdef ARB_FAIR_EN
            fair_cnt <= 2'd0;
`endif
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (grant_d) begin
                        state   <= BUSY_D;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                    end else if (grant_i) begin
                        state  <= BUSY_I;
                        m_req  <= 1'b1;
                        m_we   <= 1'b0;
                        m_addr <= i_addr;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (done || timeout) begin
                        state <= IDLE;
                        m_req <= 1'b0;
                        m_we  <= 1'b0;
                        if (state == BUSY_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= timeout ? '0 : m_rdata;
                        end else begin
                            d_ack <= 1'b1;
                            if (timeout) d_rdata <= '0;
                            else if (!m_we) d_rdata <= m_rdata;
                        end
                        if (timeout) err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef ARB_FAIR_EN
            if (grant_i) fair_cnt <= 2'd0;
            else if (grant_d) fair_cnt <= i_req ? fair_cnt + 2'd1 : 2'd0;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected acks and memory
// transactions; a memory responder and an ack monitor pop and compare.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_txn_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_ack, d_req, d_we, d_ack, m_req, m_we, m_ready, err;
    logic [AW-1:0] i_addr, d_addr, m_addr;
    logic [DW-1:0] i_rdata, d_wdata, d_rdata, m_wdata, m_rdata;

    logic [DW-1:0] i_q[$];
    logic [DW-1:0] d_q[$];
    mem_txn_t      m_q[$];

    int checks = 0;
    int errors = 0;
    int mreq_total = 0;
    int mem_lat = 1;
    logic mem_en = 1'b1;
    logic force_ready = 1'b0;
    logic [DW-1:0] last_d = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 32'd0) return 32'h2002_0005;
        if (a == 32'd80) return 32'h0000_0055;
        return 32'hC0DE_0000 | a;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ack monitor
    always @(negedge clk) begin
        if (m_req) mreq_total++;
        if (i_ack) begin
            if (i_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL i_ack_unexpected: got i_ack=1 expected 0");
            end else check("i_rdata", i_rdata, i_q.pop_front());
        end
        if (d_ack) begin
            if (d_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL d_ack_unexpected: got d_ack=1 expected 0");
            end else check("d_rdata", d_rdata, d_q.pop_front());
        end
    end

    // Memory responder: checks every request cycle against the expected transaction
    initial begin
        int       wait_cnt;
        logic     active;
        mem_txn_t cur;
        m_ready = 1'b0; m_rdata = '0; wait_cnt = 0; active = 1'b0; cur = '0;
        forever begin
            @(posedge clk); #1;
            m_ready = force_ready;
            if (!m_req) begin
                active = 1'b0; wait_cnt = 0;
            end else begin
                if (!active) begin
                    active = 1'b1; wait_cnt = 0;
                    if (m_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL m_req_unexpected: got addr %h expected no request", m_addr);
                        cur = {m_we, m_addr, m_wdata};
                    end else cur = m_q.pop_front();
                end
                check("m_we", {31'd0, m_we}, {31'd0, cur.we});
                check("m_addr", m_addr, cur.addr);
                if (cur.we) check("m_wdata", m_wdata, cur.wdata);
                wait_cnt++;
                if (mem_en && wait_cnt >= mem_lat) begin
                    m_ready = 1'b1;
                    m_rdata = mem_word(m_addr);
                    active  = 1'b0;
                end
            end
        end
    end

    task automatic do_i(input logic [AW-1:0] addr);
        i_addr = addr; i_req = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (i_ack) begin i_req = 1'b0; return; end
        end
        i_req = 1'b0; checks++; errors++;
        $display("FAIL i_ack_timeout: got no i_ack expected one within 60 cycles");
    endtask

    task automatic do_d(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (d_ack) begin d_req = 1'b0; return; end
        end
        d_req = 1'b0; checks++; errors++;
        $display("FAIL d_ack_timeout: got no d_ack expected one within 60 cycles");
    endtask

    task automatic push_i(input logic [AW-1:0] addr);
        m_q.push_back({1'b0, addr, 32'd0});
        i_q.push_back(mem_word(addr));
    endtask

    task automatic push_d(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        m_q.push_back({we, addr, wdata});
        if (!we) last_d = mem_word(addr);
        d_q.push_back(last_d);
    endtask

    initial begin
        int snap;
        rst = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;

        // 1: reset with stray m_ready pulses
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            force_ready = n[0];
        end
        force_ready = 1'b0;
        @(negedge clk);
        check("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
        check("rst_mreq_we_err", {29'd0, m_req, m_we, err}, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            force_ready = ~n[0];
        end
        force_ready = 1'b0;
        @(negedge clk);
        check("idle_ready_ignored", {31'd0, m_req}, 32'd0);

        // 2: fetch, latency 1
        push_i(32'h0);
        do_i(32'h0);

        // 3: store, latency 3
        mem_lat = 3;
        push_d(1'b1, 32'd84, 32'd7);
        do_d(1'b1, 32'd84, 32'd7);
        mem_lat = 1;

        // 4: simultaneous requests, D first
        push_d(1'b0, 32'd80, '0);
        push_i(32'h0C);
        fork
            do_d(1'b0, 32'd80, '0);
            do_i(32'h0C);
        join
        check("d_rdata_hold", d_rdata, 32'h55);

        // 6: D held high with I pending
`ifdef ARB_FAIR_EN
        push_d(1'b0, 32'd100, '0); push_d(1'b0, 32'd104, '0); push_i(32'h4);
        push_d(1'b0, 32'd108, '0); push_d(1'b0, 32'd112, '0); push_i(32'h8);
`else
        push_d(1'b0, 32'd100, '0); push_d(1'b0, 32'd104, '0);
        push_d(1'b0, 32'd108, '0); push_d(1'b0, 32'd112, '0);
        push_i(32'h4); push_i(32'h8);
`endif
        fork
            for (int k = 0; k < 4; k++) do_d(1'b0, 32'd100 + 32'(4 * k), '0);
            begin do_i(32'h4); do_i(32'h8); end
        join

        // 5: watchdog timeout
        mem_en = 1'b0;
        m_q.push_back({1'b0, 32'h40, 32'd0});
        i_q.push_back(32'd0);
        snap = mreq_total;
        do_i(32'h40);
        check("timeout_mreq_cycles", 32'(mreq_total - snap), 32'd4);
        check("timeout_err", {31'd0, err}, 32'd1);
        mem_en = 1'b1;
        push_d(1'b0, 32'h200, '0);
        do_d(1'b0, 32'h200, '0);
        check("err_sticky", {31'd0, err}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("err_cleared", {31'd0, err}, 32'd0);

        repeat (3) @(posedge clk);
        check("i_q_drained", 32'(i_q.size()), 32'd0);
        check("d_q_drained", 32'(d_q.size()), 32'd0);
        check("m_q_drained", 32'(m_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running expected finish");
        $fatal(1, "global timeout");
    end

endmodule
